// File: rtl/isolde_decoder_pkg.sv
// Shared types and defaults for the instruction window feeding the decoder.
// Holds the window FSM state encoding and the default batch geometry.
package isolde_decoder_pkg;

    localparam int unsigned WINDOW_DEFAULT = 5;
    localparam int unsigned SKID_DEFAULT   = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        HOLD
    } win_state_e;

    // Running state implied by a fill level once no stall is pending.
    function automatic win_state_e state_for_fill(
        input logic [2:0] fill,
        input logic [2:0] full
    );
        if (fill == 3'd0) return IDLE;
        if (fill == full) return STREAM;
        return PRIME;
    endfunction

endpackage

// File: rtl/isolde_skid_fifo.sv
// Small skid FIFO with a registered ready and synchronous flush.
// Ready reflects the occupancy left after this cycle's push/pop.
module isolde_skid_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             ready,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [CW-1:0]               count_q;
    logic [CW-1:0]               count_d;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign head_valid = (count_q != '0);
    assign head_data  = mem[rd_ptr];

    // Occupancy after this cycle's push/pop, cleared by flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointers, occupancy and the registered ready flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            ready   <= 1'b1;
        end else begin
            count_q <= count_d;
            ready   <= (count_d < CW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= bump(wr_ptr);
                if (pop)  rd_ptr <= bump(rd_ptr);
            end
        end
    end

    // Storage array; contents behind the pointers are don't-care.
    always_ff @(posedge clk_i) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    a_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (push && !flush) |-> (count_q < CW'(DEPTH))
    );

    a_no_underflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (pop && !flush) |-> (count_q != '0)
    );

endmodule

// File: rtl/isolde_instr_window.sv
// Sliding window of fetched words presented to the decoder as a batch.
// Words shift in one per cycle, bypassing the skid FIFO when it is empty.
module isolde_instr_window
    import isolde_decoder_pkg::*;
#(
    parameter int unsigned WINDOW     = WINDOW_DEFAULT,
    parameter int unsigned SKID_DEPTH = SKID_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   stall_i,
    input  logic                   in_valid_i,
    input  logic [31:0]            in_instr_i,
    output logic                   in_ready_o,
    output logic [WINDOW-1:0][31:0] batch_o,
    output logic                   batch_valid_o,
    output logic [2:0]             fill_o,
    output logic                   primed_o
);

    localparam logic [2:0] FULL = 3'(WINDOW);

    logic        accept;
    logic        shift;
    logic        pop;
    logic        push;
    logic        head_valid;
    logic [31:0] head;
    logic [31:0] new_word;
    logic [2:0]  fill_d;

    logic [WINDOW-1:0][31:0] batch_q;
    logic                    batch_valid_q;
    logic [2:0]              fill_q;
    win_state_e              state_q;
    win_state_e              state_d;

    assign accept   = in_valid_i && in_ready_o;
    assign shift    = !stall_i && !flush_i && (head_valid || accept);
    assign pop      = shift && head_valid;
    assign push     = accept && !flush_i && !(shift && !head_valid);
    assign new_word = head_valid ? head : in_instr_i;
    assign fill_d   = (shift && fill_q != FULL) ? fill_q + 3'd1 : fill_q;

    isolde_skid_fifo #(
        .WIDTH (32),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush      (flush_i),
        .push       (push),
        .push_data  (in_instr_i),
        .ready      (in_ready_o),
        .pop        (pop),
        .head_valid (head_valid),
        .head_data  (head)
    );

    // Window shift register, shift pulse and saturating fill count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            batch_q       <= '0;
            batch_valid_q <= 1'b0;
            fill_q        <= '0;
        end else if (flush_i) begin
            batch_q       <= '0;
            batch_valid_q <= 1'b0;
            fill_q        <= '0;
        end else if (shift) begin
            for (int k = WINDOW - 1; k > 0; k--) begin
                batch_q[k] <= batch_q[k-1];
            end
            batch_q[0]    <= new_word;
            batch_valid_q <= 1'b1;
            fill_q        <= fill_d;
        end else begin
            batch_valid_q <= 1'b0;
        end
    end

    // Window state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: prime, stream, hold on stall, flush back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (shift) state_d = state_for_fill(fill_d, FULL);
            end
            PRIME, STREAM: begin
                if (stall_i)    state_d = HOLD;
                else if (shift) state_d = state_for_fill(fill_d, FULL);
            end
            HOLD: begin
                if (!stall_i) state_d = state_for_fill(fill_d, FULL);
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    assign batch_o       = batch_q;
    assign batch_valid_o = batch_valid_q;
    assign fill_o        = fill_q;
    assign primed_o      = (fill_q == FULL);

endmodule

// File: tb/tb_isolde_instr_window.sv
// Bench for isolde_instr_window: directed scenarios plus random traffic.
// A queue-based model of accepted-but-unshifted words is compared every cycle.
module tb_isolde_instr_window;
    import isolde_decoder_pkg::*;

    localparam int W = 5;
    localparam int D = 2;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              flush    = 1'b0;
    logic              stall    = 1'b0;
    logic              in_valid = 1'b0;
    logic [31:0]       in_instr = '0;
    logic              in_ready;
    logic [W-1:0][31:0] batch;
    logic              batch_valid;
    logic [2:0]        fill;
    logic              primed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    isolde_instr_window #(
        .WINDOW     (W),
        .SKID_DEPTH (D)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .flush_i       (flush),
        .stall_i       (stall),
        .in_valid_i    (in_valid),
        .in_instr_i    (in_instr),
        .in_ready_o    (in_ready),
        .batch_o       (batch),
        .batch_valid_o (batch_valid),
        .fill_o        (fill),
        .primed_o      (primed)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Model: window contents, pending words, and the ready they imply.
    logic [31:0] m_win[W] = '{default: 32'h0};
    int          m_fill   = 0;
    bit          m_bv     = 1'b0;
    bit          m_ready  = 1'b1;
    logic [31:0] m_pend[$];

    always @(posedge clk or negedge rst_n) begin
        bit acc;
        bit shifted;
        if (!rst_n) begin
            foreach (m_win[k]) m_win[k] = '0;
            m_fill  = 0;
            m_bv    = 1'b0;
            m_ready = 1'b1;
            m_pend.delete();
        end else begin
            acc     = in_valid && m_ready;
            shifted = 1'b0;
            if (flush) begin
                foreach (m_win[k]) m_win[k] = '0;
                m_fill = 0;
                m_pend.delete();
            end else begin
                if (acc) m_pend.push_back(in_instr);
                if (!stall && m_pend.size() > 0) begin
                    for (int k = W - 1; k > 0; k--) m_win[k] = m_win[k-1];
                    m_win[0] = m_pend.pop_front();
                    shifted  = 1'b1;
                    if (m_fill < W) m_fill++;
                end
            end
            m_bv    = shifted;
            m_ready = (m_pend.size() < D);
        end
    end

    // Compare DUT against the model shortly after each active edge.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("cmp_in_ready", 32'(in_ready), 32'(m_ready));
            check("cmp_batch_valid", 32'(batch_valid), 32'(m_bv));
            check("cmp_fill", 32'(fill), 32'(m_fill));
            check("cmp_primed", 32'(primed), 32'(m_fill == W));
            for (int k = 0; k < W; k++) begin
                check($sformatf("cmp_batch%0d", k), batch[k], m_win[k]);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] d,
                       input logic st, input logic fl);
        in_valid = v;
        in_instr = d;
        stall    = st;
        flush    = fl;
        @(negedge clk);
    endtask

    initial begin
        int pulses;
        logic [31:0] seq;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_batch_valid", 32'(batch_valid), 32'd0);
        check("rst_primed", 32'(primed), 32'd0);
        check("rst_batch0", batch[0], 32'h0);
        rst_n = 1'b1;

        // Back-to-back fill of the window.
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h11 * (i + 1), 1'b0, 1'b0);
            check("prime_fill", 32'(fill), 32'(i + 1));
            check("prime_pulse", 32'(batch_valid), 32'd1);
            if (batch_valid) pulses++;
        end
        check("prime_batch0", batch[0], 32'h55);
        check("prime_batch4", batch[4], 32'h11);
        check("prime_primed", 32'(primed), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("prime_idle_pulse", 32'(batch_valid), 32'd0);
        check("prime_pulse_count", 32'(pulses), 32'd5);

        // Stall with three words offered; only two fit in the skid.
        cyc(1'b1, 32'hA0, 1'b1, 1'b0);
        check("stall_ready1", 32'(in_ready), 32'd1);
        check("stall_batch0_a", batch[0], 32'h55);
        cyc(1'b1, 32'hA1, 1'b1, 1'b0);
        check("stall_ready2", 32'(in_ready), 32'd0);
        cyc(1'b1, 32'hA2, 1'b1, 1'b0);
        cyc(1'b1, 32'hA2, 1'b1, 1'b0);
        check("stall_batch0_b", batch[0], 32'h55);
        check("stall_fill", 32'(fill), 32'd5);
        check("stall_pulse", 32'(batch_valid), 32'd0);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        check("release_a0", batch[0], 32'hA0);
        check("release_pulse", 32'(batch_valid), 32'd1);
        cyc(1'b1, 32'hA2, 1'b0, 1'b0);
        check("release_a1", batch[0], 32'hA1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("release_a2", batch[0], 32'hA2);
        check("release_b1", batch[1], 32'hA1);
        check("release_b2", batch[2], 32'hA0);
        check("release_b3", batch[3], 32'h55);

        // Flush beats stall and input in the same cycle.
        cyc(1'b1, 32'hB0, 1'b1, 1'b0);
        cyc(1'b1, 32'hB1, 1'b1, 1'b1);
        check("flush_fill", 32'(fill), 32'd0);
        check("flush_batch0", batch[0], 32'h0);
        check("flush_batch4", batch[4], 32'h0);
        check("flush_pulse", 32'(batch_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_primed", 32'(primed), 32'd0);
        check("flush_state", 32'(dut.state_q), 32'(IDLE));
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_empty_pulse", 32'(batch_valid), 32'd0);
        check("flush_empty_fill", 32'(fill), 32'd0);

        // Asynchronous reset with two words waiting in the skid.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 32'h61 + 32'(i), 1'b0, 1'b0);
        end
        cyc(1'b1, 32'h66, 1'b1, 1'b0);
        cyc(1'b1, 32'h67, 1'b1, 1'b0);
        check("arst_pre_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        stall    = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_fill", 32'(fill), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_pulse", 32'(batch_valid), 32'd0);
        check("arst_batch0", batch[0], 32'h0);
        check("arst_primed", 32'(primed), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h77, 1'b0, 1'b0);
        check("arst_after_batch0", batch[0], 32'h77);
        check("arst_after_fill", 32'(fill), 32'd1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // Random valid/stall/flush traffic against the model.
        seq = 32'h1000_0000;
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom_range(0, 1)), seq,
                1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 63) == 0));
            seq++;
        end
        repeat (4) cyc(1'b0, 32'h0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isolde_instr_window.md
ISOLDE_INSTR_WINDOW -- requirements
Module: isolde_instr_window

Interface
REQ-001 Parameter WINDOW, default 5, number of 32-bit words presented to the decoder as a batch.
REQ-002 Parameter SKID_DEPTH, default 2, entries in the input skid FIFO.
REQ-003 clk_i  input  1  clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous discard of window, skid FIFO and fill count.
REQ-006 stall_i  input  1  downstream decoder busy; freezes window shifting.
REQ-007 in_valid_i  input  1  fetch word valid.
REQ-008 in_instr_i  input  32  fetched instruction word.
REQ-009 in_ready_o  output  1  registered; skid FIFO can accept a word this cycle.
REQ-010 batch_o  output  WINDOW x 32  sliding window; batch_o[0] newest word, batch_o[k] word accepted k shifts earlier.
REQ-011 batch_valid_o  output  1  one-cycle pulse in each cycle where batch_o changed by a shift.
REQ-012 fill_o  output  3  valid words in window, saturates at WINDOW.
REQ-013 primed_o  output  1  high when fill_o == WINDOW.

Function
REQ-014 Input handshake: word accepted iff in_valid_i && in_ready_o at the clock edge.
REQ-015 in_ready_o SHALL be the registered value of (FIFO occupancy after this cycle's push/pop < SKID_DEPTH); no combinational path from stall_i or in_valid_i.
REQ-016 Shift occurs in a cycle iff !stall_i && !flush_i && a word is available (FIFO head, or the accepted input when FIFO empty, bypassing the FIFO).
REQ-017 Bypass shift: word accepted at edge N appears in batch_o[0] after edge N (latency 1 cycle) when FIFO empty and !stall_i.
REQ-018 On shift: batch_o[k] <= batch_o[k-1] for k=1..WINDOW-1, batch_o[0] <= new word, batch_valid_o <= 1 for exactly that following cycle.
REQ-019 At most one shift per cycle; surplus accepted words queue in FIFO in arrival order.
REQ-020 Simultaneous push and pop on a full FIFO is legal only if in_ready_o was high; occupancy unchanged.
REQ-021 FIFO pointers wrap modulo SKID_DEPTH; overflow impossible by REQ-015, asserted.
REQ-022 fill_o increments per shift until WINDOW, then holds.
REQ-023 FSM states: IDLE (fill 0), PRIME (0<fill<WINDOW), STREAM (fill==WINDOW, not stalled), HOLD (stall_i high and fill>0).
REQ-024 Transitions: IDLE->PRIME on first shift; PRIME->STREAM on shift reaching WINDOW; PRIME/STREAM->HOLD on stall_i; HOLD->PRIME or STREAM (by fill) when stall_i drops; any state->IDLE on flush_i.
REQ-025 In HOLD batch_o, fill_o stable and batch_valid_o low; input still accepted into FIFO while in_ready_o.
REQ-026 flush_i takes priority over stall_i and input in the same cycle: next cycle fill_o=0, FIFO empty, batch_valid_o=0, in_ready_o=1; word presented in the flush cycle is dropped.
REQ-027 batch_o contents after flush are don't-care but SHALL be zeroed for determinism.

Reset
REQ-028 Reset values: batch_o all zero, batch_valid_o 0, fill_o 0, primed_o 0, in_ready_o 1, FIFO empty, state IDLE.
REQ-029 Reset asserted mid-operation discards all buffered words immediately (asynchronous); first accepted word after release lands in batch_o[0] with fill_o=1.

Structure
REQ-030 State enum and WINDOW default constant SHALL live in isolde_decoder_pkg.
REQ-031 Skid FIFO SHALL be a sub-module isolde_skid_fifo (parameterised width/depth, valid/ready, flush).
REQ-032 batch_o width and ordering SHALL match the decoder's 5x32 batch input directly, no adaptor.

Verification
REQ-033 Reset, feed 0x11,0x22,0x33,0x44,0x55 back-to-back -> fill_o 1..5, primed_o after 5th shift, batch_o[0]=0x55, batch_o[4]=0x11, five batch_valid_o pulses.
REQ-034 Primed window, stall_i high 4 cycles while feeding 0xA0,0xA1,0xA2 -> in_ready_o low after 2 accepted, batch_o unchanged; on release 0xA0,0xA1,0xA2 shift on consecutive cycles, order preserved.
REQ-035 flush_i in same cycle as in_valid_i=1 with stall_i=1 -> next cycle fill_o=0, state IDLE, FIFO empty, word dropped.
REQ-036 rst_ni pulled low mid-stream with 2 FIFO entries -> outputs at reset values asynchronously; after release word 0x77 gives batch_o[0]=0x77, fill_o=1.
REQ-037 Random valid/stall toggling 10k cycles vs. scoreboard -> every accepted word appears exactly once in batch_o[0] in order, no overflow assertion.
